// File: rtl/debug_bus_probe_pkg.sv
// debug_bus_probe_pkg
//   Shared definitions for the debug bus probe and the hex overlay renderer.
//   - state_t     : probe FSM state codes (IDLE=0, ARMED=1, CAPTURE=2, HOLD=3)
//   - DBG_*       : bit offsets and widths of the fields inside the 64-bit
//                   debug word, so the renderer can slice the same word.
//   - sat_inc16   : saturating 16-bit increment used for the hit counter.
//   - pack_debug  : assembles the 64-bit debug word from its fields.
package debug_bus_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int DBG_W         = 64;

  localparam int DBG_HIT_LSB   = 48;
  localparam int DBG_HIT_W     = 16;
  localparam int DBG_ADDR_LSB  = 32;
  localparam int DBG_ADDR_W    = 16;
  localparam int DBG_PREV_LSB  = 24;
  localparam int DBG_PREV_W    = 8;
  localparam int DBG_LAST_LSB  = 16;
  localparam int DBG_LAST_W    = 8;
  localparam int DBG_FRAME_LSB = 0;
  localparam int DBG_FRAME_W   = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DBG_W-1:0] pack_debug(
    input logic [15:0] hit,
    input logic [15:0] addr,
    input logic [7:0]  prev,
    input logic [7:0]  last,
    input logic [15:0] frame
  );
    logic [DBG_W-1:0] w;
    w = '0;
    w[DBG_HIT_LSB   +: DBG_HIT_W]   = hit;
    w[DBG_ADDR_LSB  +: DBG_ADDR_W]  = addr;
    w[DBG_PREV_LSB  +: DBG_PREV_W]  = prev;
    w[DBG_LAST_LSB  +: DBG_LAST_W]  = last;
    w[DBG_FRAME_LSB +: DBG_FRAME_W] = frame;
    return w;
  endfunction

endpackage

// File: rtl/debug_bus_probe_edge_detect.sv
// debug_edge_detect
//   Registers a level and flags its rising edge. The pulse is combinational
//   from the current level and the registered copy, so a level that is
//   already high when reset releases pulses on the first clock edge, and a
//   level held high pulses only once.
// Ports:
//   clk        system clock
//   i_reset_n  asynchronous active-low reset (clears the registered copy)
//   i_level    level to watch
//   o_level_q  level delayed by one clock
//   o_rise     i_level & ~o_level_q
module debug_edge_detect (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_level,
  output logic o_level_q,
  output logic o_rise
);

  logic level_p0;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_p0 <= 1'b0;
    end else begin
      level_p0 <= i_level;
    end
  end

  assign o_level_q = level_p0;
  assign o_rise    = i_level & ~level_p0;

endmodule

// File: rtl/debug_bus_probe.sv
// debug_bus_probe
//   Watches a CPU write bus and captures writes whose address matches
//   MATCH_ADDR under MATCH_MASK. Captured fields live in a capture stage
//   (_p0) that updates every recorded write; a display stage (_p1) copies
//   them into o_debug only on the rising edge of vblank so the overlay never
//   shows a half-updated word within a frame.
//   An arm/trigger/hold FSM gates recording:
//     IDLE    -> matches ignored
//     ARMED   -> first match records and enters CAPTURE
//     CAPTURE -> every match records; reaching HOLD_HITS enters HOLD
//     HOLD    -> live fields frozen until the next arm
//   i_arm in any state clears the live fields and re-arms; it beats a
//   same-cycle match.
// Parameters:
//   MATCH_ADDR  address compared against i_bus_addr
//   MATCH_MASK  1 = bit compared, 0 = don't care
//   HOLD_HITS   hit count that freezes capture (0 = never freeze)
// Ports:
//   clk          system clock
//   i_reset_n    asynchronous active-low reset
//   i_arm        one-cycle pulse: clear capture, arm trigger
//   i_bus_we     CPU write strobe
//   i_bus_addr   CPU write address [15:0]
//   i_bus_data   CPU write data [7:0]
//   i_vblank     vertical blank level
//   o_debug      {hit_count, last_addr, prev_data, last_data, frame_count}
//   o_state      FSM state code
//   o_triggered  high in CAPTURE or HOLD
module debug_bus_probe
  import debug_bus_probe_pkg::*;
#(
  parameter logic [15:0] MATCH_ADDR = 16'h0000,
  parameter logic [15:0] MATCH_MASK = 16'hFFFF,
  parameter logic [15:0] HOLD_HITS  = 16'd0
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_arm,
  input  logic        i_bus_we,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_data,
  input  logic        i_vblank,
  output logic [63:0] o_debug,
  output logic [1:0]  o_state,
  output logic        o_triggered
);

  state_t      state_q;
  state_t      state_d;

  logic        match;
  logic        rec_vld;
  logic        vb_q;
  logic        vb_rise;

  logic [15:0] hit_cnt_p0;
  logic [15:0] last_addr_p0;
  logic [7:0]  prev_data_p0;
  logic [7:0]  last_data_p0;
  logic [15:0] frame_cnt_p0;
  logic [15:0] hit_inc;
  logic [15:0] frame_inc;

  logic [63:0] debug_p1;

  debug_edge_detect u_vb_edge (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_vblank),
    .o_level_q (vb_q),
    .o_rise    (vb_rise)
  );

  assign match     = i_bus_we &
                     ((i_bus_addr & MATCH_MASK) == (MATCH_ADDR & MATCH_MASK));
  assign hit_inc   = sat_inc16(hit_cnt_p0);
  // Frame counter wraps rather than saturates.
  assign frame_inc = frame_cnt_p0 + 16'd1;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rec_vld marks a match that is actually recorded this cycle. The HOLD
  // test uses the post-update count, so the write that reaches HOLD_HITS is
  // itself recorded before the freeze.
  always_comb begin
    state_d = state_q;
    rec_vld = 1'b0;
    if (i_arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ARMED, ST_CAPTURE: begin
          if (match) begin
            rec_vld = 1'b1;
            if ((HOLD_HITS != 16'd0) && (hit_inc == HOLD_HITS)) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_CAPTURE;
            end
          end
        end
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture stage: live fields, updated by arm or a recorded write.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_cnt_p0   <= 16'd0;
      last_addr_p0 <= 16'd0;
      prev_data_p0 <= 8'd0;
      last_data_p0 <= 8'd0;
    end else if (i_arm) begin
      hit_cnt_p0   <= 16'd0;
      last_addr_p0 <= 16'd0;
      prev_data_p0 <= 8'd0;
      last_data_p0 <= 8'd0;
    end else if (rec_vld) begin
      hit_cnt_p0   <= hit_inc;
      last_addr_p0 <= i_bus_addr;
      prev_data_p0 <= last_data_p0;
      last_data_p0 <= i_bus_data;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_cnt_p0 <= 16'd0;
    end else if (vb_rise) begin
      frame_cnt_p0 <= frame_inc;
    end
  end

  // Display stage: snapshot of the live fields as they stood before this
  // edge, so a write coinciding with vb_rise shows up one frame later.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      debug_p1 <= 64'd0;
    end else if (vb_rise) begin
      debug_p1 <= pack_debug(hit_cnt_p0, last_addr_p0, prev_data_p0,
                             last_data_p0, frame_inc);
    end
  end

  assign o_debug     = debug_p1;
  assign o_state     = state_q;
  assign o_triggered = (state_q == ST_CAPTURE) || (state_q == ST_HOLD);

endmodule
